// File: rtl/restcomp_serial.sv
// restcomp_serial: bit-serial two's-complement subtractor, X = S - Y = S + ~Y + 1.
// One bit per clock, LSB first, under a start/done handshake.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   start  in  1  request, sampled only in IDLE
//   s      in  N  minuend, captured on accepted start
//   y      in  N  subtrahend, captured on accepted start
//   x      out N  result S - Y mod 2^N, registered
//   cout   out 1  final carry of S + ~Y + 1 (1 = no unsigned borrow)
//   ovf    out 1  signed overflow of the subtraction
//   busy   out 1  high while in RUN
//   done   out 1  one-cycle completion pulse
module restcomp_serial #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] s,
   input  logic [N-1:0] y,
   output logic [N-1:0] x,
   output logic         cout,
   output logic         ovf,
   output logic         busy,
   output logic         done
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [N-1:0]  a_sr;      // minuend, shifted right each RUN edge
   logic [N-1:0]  b_sr;      // inverted subtrahend, shifted right each RUN edge
   logic [N-1:0]  r_sr;      // result, filled from the MSB side
   logic          carry;
   logic [CW-1:0] count;

   logic          sum_bit;
   logic          carry_nxt;
   logic [N-1:0]  r_nxt;

   assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
   assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign r_nxt     = {sum_bit, r_sr[N-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         carry <= 1'b0;
         count <= '0;
         x     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= s;
                  b_sr  <= ~y;
                  carry <= 1'b1;     // the +1 of the two's complement
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               r_sr  <= r_nxt;
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= carry_nxt;
               count <= count + 1'b1;
               if (count == LAST) begin
                  // carry here is the carry into the MSB; overflow is its
                  // disagreement with the carry out of the MSB
                  x     <= r_nxt;
                  cout  <= carry_nxt;
                  ovf   <= carry ^ carry_nxt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_restcomp_serial.sv
// tb_restcomp_serial: self-checking bench for restcomp_serial, using directed
// cases, adder round-trips over all 4-bit pairs and random operands, all
// compared against an arithmetic reference model.
module tb_restcomp_serial;

   localparam int N    = 4;
   localparam int MASK = (1 << N) - 1;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] s;
   logic [N-1:0] y;
   logic [N-1:0] x;
   logic         cout;
   logic         ovf;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   restcomp_serial #(.N(N)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .s    (s),
      .y    (y),
      .x    (x),
      .cout (cout),
      .ovf  (ovf),
      .busy (busy),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic int ref_x(input int sv, input int yv);
      return (sv - yv) & MASK;
   endfunction

   function automatic int ref_cout(input int sv, input int yv);
      return ((sv + ((~yv) & MASK) + 1) >> N) & 1;
   endfunction

   function automatic int ref_ovf(input int sv, input int yv);
      int ss, sy, sx;
      ss = (sv >> (N - 1)) & 1;
      sy = (yv >> (N - 1)) & 1;
      sx = (ref_x(sv, yv) >> (N - 1)) & 1;
      return ((ss != sy) && (sx != ss)) ? 1 : 0;
   endfunction

   // Wait (bounded) for done; counts busy cycles seen before it.
   task automatic wait_done(output bit got, output int bcnt, input bit chg);
      got  = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 3 * N + 10 && !got; i++) begin
         @(negedge clk);
         if (chg) begin
            s = N'($urandom);
            y = N'($urandom);
         end
         if (done) got = 1'b1;
         else if (busy) bcnt++;
      end
      if (!got) chk("timeout", 0, 1);
   endtask

   task automatic check_res(input string tag, input int sv, input int yv);
      chk({tag, "_x"},    x,    ref_x(sv, yv));
      chk({tag, "_cout"}, cout, ref_cout(sv, yv));
      chk({tag, "_ovf"},  ovf,  ref_ovf(sv, yv));
   endtask

   // One operation. hold keeps start high through RUN/DONE; chg scrambles s/y during RUN.
   task automatic do_op(input string tag, input int sv, input int yv, input bit hold, input bit chg);
      bit got;
      int bcnt;
      @(negedge clk);
      s     = N'(sv);
      y     = N'(yv);
      start = 1'b1;
      @(negedge clk);
      chk({tag, "_busy_acc"}, busy, 1);
      if (!hold) start = 1'b0;
      wait_done(got, bcnt, chg);
      if (got) begin
         chk({tag, "_busy_len"}, bcnt + 1, N);
         chk({tag, "_busy_dn"}, busy, 0);
         check_res(tag, sv, yv);
         @(negedge clk);
         chk({tag, "_done_once"}, done, 0);
         if (hold) begin
            chk({tag, "_idle_busy"}, busy, 0);
            @(negedge clk);
            chk({tag, "_recapture"}, busy, 1);
            start = 1'b0;
            wait_done(got, bcnt, 1'b0);
            if (got) check_res({tag, "_re"}, sv, yv);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      bit got;
      int bcnt;
      int a, b, dn;
      rst_n = 1'b0;
      start = 1'b0;
      s     = '0;
      y     = '0;
      #12;
      chk("rst_x", x, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("t2", 4'b1011, 4'b0101, 1'b0, 1'b0);
      do_op("t3", 4'b0111, 4'b1111, 1'b0, 1'b0);
      do_op("t4", 4'b1111, 4'b1110, 1'b1, 1'b0);
      do_op("t5", 4'b0000, 4'b0000, 1'b0, 1'b1);

      // x/cout/ovf hold while idle
      do_op("hold", 4'b1011, 4'b0101, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_res("hold_idle", 4'b1011, 4'b0101);

      // asynchronous reset mid-RUN
      @(negedge clk);
      s     = 4'b0011;
      y     = 4'b0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_x", x, 0);
      chk("arst_cout", cout, 0);
      chk("arst_ovf", ovf, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (N + 4) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("arst_no_done", dn, 0);

      // round-trip against the adder: s = a + b, y = b -> x = a
      for (a = 0; a <= MASK; a++) begin
         for (b = 0; b <= MASK; b++) begin
            @(negedge clk);
            s     = N'((a + b) & MASK);
            y     = N'(b);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(got, bcnt, 1'b0);
            if (got) begin
               chk("rt_x", x, a);
               chk("rt_cout", cout, ref_cout((a + b) & MASK, b));
               chk("rt_ovf", ovf, ref_ovf((a + b) & MASK, b));
               @(negedge clk);
               chk("rt_done_once", done, 0);
            end
         end
      end

      // random operands, occasionally scrambling inputs mid-operation
      for (int i = 0; i < 40; i++) begin
         do_op("rnd", int'($urandom & MASK), int'($urandom & MASK), 1'b0, 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
